// File: rtl/qm_tx_if.sv
// qm_tx_if: qm FIFO read side, MAC transmit burst and status bundle for qm_tx
// master: qm_tx (pops FIFOs, drives tx_* and status); slave: qm FIFOs + port MAC.
interface qm_tx_if;
    logic        ptr_fifo_empty;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic        tx_dv;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    modport master (
        input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_ready,
        output ptr_fifo_rd, data_fifo_rd, tx_sof, tx_eof, tx_dv, tx_data, busy, frame_cnt, drop_cnt
    );
    modport slave (
        output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_ready,
        input  ptr_fifo_rd, data_fifo_rd, tx_sof, tx_eof, tx_dv, tx_data, busy, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/qm_tx.sv
// qm_tx: queue-manager output reader streaming descriptor-sized frames to the port MAC
// clk, rst: clock and asynchronous active-high reset.
// q (qm_tx_if.master): pointer/data FIFO pops with 1-cycle read latency, registered
// tx_sof/tx_eof/tx_dv/tx_data burst gated frame-wise by tx_ready, busy/frame_cnt/drop_cnt.
module qm_tx #(
    parameter int IFG = 12
) (
    input logic     clk,
    input logic     rst,
    qm_tx_if.master q
);
    typedef enum logic [2:0] {IDLE, POP, LEN, READ, DRAIN, GAP} state_t;
    state_t      state, state_n;
    logic [11:0] len, len_n, cnt, cnt_n, dlen;
    logic [15:0] gcnt, gcnt_n;
    logic [7:0]  drop_n;
    logic        ptr_rd_n, data_rd_n, rd_d1, first_d1, last_d1, unused_hi;
    assign dlen = q.ptr_fifo_dout[11:0];
    assign unused_hi = ^q.ptr_fifo_dout[15:12];
    always_comb begin
        state_n   = state;
        ptr_rd_n  = 1'b0;
        data_rd_n = 1'b0;
        len_n     = len;
        cnt_n     = cnt;
        gcnt_n    = gcnt;
        drop_n    = q.drop_cnt;
        case (state)
            IDLE: if (!q.ptr_fifo_empty && q.tx_ready) begin
                ptr_rd_n = 1'b1;
                state_n  = POP;
            end
            POP: state_n = LEN;
            LEN: begin
                len_n = dlen;
                if (dlen == 12'd0) begin
                    drop_n  = q.drop_cnt + 8'(q.drop_cnt != 8'hFF);
                    state_n = IDLE;
                end else begin
                    data_rd_n = 1'b1;
                    cnt_n     = 12'd1;
                    state_n   = READ;
                end
            end
            READ: if (cnt == len) state_n = DRAIN;
            else begin
                data_rd_n = 1'b1;
                cnt_n     = cnt + 12'd1;
            end
            // Leaving one cycle after tx_eof makes the idle gap exactly IFG+5 back to back.
            DRAIN: if (q.tx_eof) begin
                gcnt_n  = 16'd0;
                state_n = GAP;
            end
            GAP: if (int'(gcnt) + 1 >= IFG) state_n = IDLE;
            else gcnt_n = gcnt + 16'd1;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            len              <= '0;
            cnt              <= '0;
            gcnt             <= '0;
            rd_d1            <= 1'b0;
            first_d1         <= 1'b0;
            last_d1          <= 1'b0;
            q.ptr_fifo_rd    <= 1'b0;
            q.data_fifo_rd   <= 1'b0;
            q.tx_sof         <= 1'b0;
            q.tx_eof         <= 1'b0;
            q.tx_dv          <= 1'b0;
            q.tx_data        <= '0;
            q.busy           <= 1'b0;
            q.frame_cnt      <= '0;
            q.drop_cnt       <= '0;
        end else begin
            state            <= state_n;
            len              <= len_n;
            cnt              <= cnt_n;
            gcnt             <= gcnt_n;
            q.ptr_fifo_rd    <= ptr_rd_n;
            q.data_fifo_rd   <= data_rd_n;
            q.busy           <= state_n != IDLE;
            q.drop_cnt       <= drop_n;
            // First/last markers ride alongside rd_d1 so they line up with the returned byte.
            rd_d1            <= q.data_fifo_rd;
            first_d1         <= state == READ && cnt == 12'd1;
            last_d1          <= state == READ && cnt == len;
            q.tx_dv          <= rd_d1;
            q.tx_data        <= rd_d1 ? q.data_fifo_dout : q.tx_data;
            q.tx_sof         <= first_d1;
            q.tx_eof         <= last_d1;
            q.frame_cnt      <= q.frame_cnt + 16'(last_d1);
        end
    end
endmodule

// File: tb/tb_qm_tx.sv
// tb_qm_tx: directed and randomized frame traffic against a FIFO/MAC reference model
module tb_qm_tx;
    localparam int IFG = 12;
    logic clk = 1'b0;
    logic rst = 1'b1;
    qm_tx_if q();
    qm_tx #(.IFG(IFG)) dut (.clk(clk), .rst(rst), .q(q));
    always #5 clk = ~clk;
    int n_chk = 0, n_pass = 0, cyc = 0, viol = 0, rd_cycles = 0, ptr_rd_cnt = 0, empty_fall = 0;
    int exp_fcnt = 0, exp_dcnt = 0;
    logic [15:0] ptr_q[$];
    logic [7:0]  data_q[$];
    logic [9:0]  obs[$], exp_q[$];
    int          sof_cyc[$], eof_cyc[$];
    logic        in_frame = 1'b0, prd = 1'b0, drd = 1'b0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            prd = 1'b0;
            drd = 1'b0;
            q.ptr_fifo_empty = 1'b1;
        end else begin
            if (prd) begin
                if (ptr_q.size() > 0) q.ptr_fifo_dout = ptr_q.pop_front();
                else viol++;
            end
            if (drd) begin
                if (data_q.size() > 0) q.data_fifo_dout = data_q.pop_front();
                else viol++;
            end
            prd = q.ptr_fifo_rd;
            drd = q.data_fifo_rd;
            if (q.ptr_fifo_empty && ptr_q.size() != 0) empty_fall = cyc;
            q.ptr_fifo_empty = ptr_q.size() == 0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst) in_frame = 1'b0;
        else begin
            if (q.ptr_fifo_rd && q.data_fifo_rd) viol++;
            if (q.ptr_fifo_rd) ptr_rd_cnt++;
            if (q.data_fifo_rd) rd_cycles++;
            if (q.tx_dv) begin
                obs.push_back({q.tx_sof, q.tx_eof, q.tx_data});
                if (q.tx_sof) begin
                    if (in_frame) viol++;
                    in_frame = 1'b1;
                    sof_cyc.push_back(cyc);
                end else if (!in_frame) viol++;
                if (q.tx_eof) begin
                    in_frame = 1'b0;
                    eof_cyc.push_back(cyc);
                end
            end else if (q.tx_sof || q.tx_eof || in_frame) viol++;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk++;
        assert (obs_v === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs_v, exp_v);
    endtask
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic clear_obs();
        obs.delete();
        exp_q.delete();
        sof_cyc.delete();
        eof_cyc.delete();
        viol = 0;
        rd_cycles = 0;
        ptr_rd_cnt = 0;
    endtask
    task automatic push_desc(input logic [15:0] d, input logic [7:0] base);
        int n = int'(d[11:0]);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (base != 8'd0) ? base + 8'(i) : 8'($urandom);
            data_q.push_back(b);
            exp_q.push_back({i == 0, i == n - 1, b});
        end
        if (n == 0) exp_dcnt = (exp_dcnt == 255) ? 255 : exp_dcnt + 1;
        else exp_fcnt++;
        ptr_q.push_back(d);
    endtask
    task automatic run_until_idle(input string tag, input int budget, input bit rnd);
        int n = 0;
        do begin
            step();
            n++;
            if (rnd) q.tx_ready = $urandom_range(0, 3) != 0;
        end while ((ptr_q.size() != 0 || q.busy) && n < budget);
        q.tx_ready = 1'b1;
        chk({tag, "_done"}, 32'(n < budget), 1);
    endtask
    task automatic wait_bytes(input string tag, input int nb, input int budget);
        int n = 0;
        while (obs.size() < nb && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(n < budget), 1);
    endtask
    task automatic check_frames(input string tag);
        int bad = 0;
        int gv = 0;
        chk({tag, "_nbytes"}, obs.size(), exp_q.size());
        foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
        for (int i = 1; i < sof_cyc.size(); i++)
            if (i > eof_cyc.size() || sof_cyc[i] - eof_cyc[i-1] - 1 < IFG + 5) gv++;
        chk({tag, "_bytes"}, bad, 0);
        chk({tag, "_gap"}, gv, 0);
        chk({tag, "_proto"}, viol, 0);
        chk({tag, "_fcnt"}, q.frame_cnt, 16'(exp_fcnt));
        chk({tag, "_dcnt"}, q.drop_cnt, 8'(exp_dcnt));
    endtask
    initial begin
        q.ptr_fifo_empty = 1'b1;
        q.ptr_fifo_dout  = '0;
        q.data_fifo_dout = '0;
        q.tx_ready       = 1'b1;
        repeat (3) step();
        chk("rst_outs", {q.ptr_fifo_rd, q.data_fifo_rd, q.tx_sof, q.tx_eof, q.tx_dv, q.tx_data, q.busy}, 0);
        chk("rst_cnts", {q.frame_cnt, q.drop_cnt}, 0);
        rst = 1'b0;
        clear_obs();
        push_desc(16'd4, 8'hA1);
        run_until_idle("len4", 100, 1'b0);
        check_frames("len4");
        chk("len4_rd", rd_cycles, 4);
        chk("len4_first", obs[0], {2'b10, 8'hA1});
        chk("len4_last", obs[3], {2'b01, 8'hA4});
        chk("len4_lat", sof_cyc[0] - empty_fall, 5);
        clear_obs();
        push_desc(16'd1, 8'd0);
        push_desc(16'd3, 8'd0);
        run_until_idle("b2b", 150, 1'b0);
        check_frames("b2b");
        chk("b2b_sofeof", obs[0][9:8], 2'b11);
        chk("b2b_gap", sof_cyc[1] - eof_cyc[0] - 1, IFG + 5);
        clear_obs();
        push_desc(16'hF000, 8'd0);
        push_desc(16'hA002, 8'd0);
        run_until_idle("zero", 150, 1'b0);
        check_frames("zero");
        chk("zero_rd", rd_cycles, 2);
        chk("zero_pops", ptr_rd_cnt, 2);
        clear_obs();
        q.tx_ready = 1'b0;
        push_desc(16'd3, 8'h30);
        repeat (20) step();
        chk("hold_nopop", ptr_rd_cnt, 0);
        chk("hold_busy", q.busy, 0);
        q.tx_ready = 1'b1;
        wait_bytes("hold", 1, 50);
        q.tx_ready = 1'b0;
        run_until_idle("hold", 100, 1'b0);
        check_frames("hold");
        clear_obs();
        for (int i = 0; i < 25; i++)
            push_desc({4'($urandom), ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom_range(1, 40))}, 8'd0);
        run_until_idle("rand", 20000, 1'b1);
        check_frames("rand");
        chk("rand_rd", rd_cycles, exp_q.size());
        clear_obs();
        push_desc(16'h0FFF, 8'd0);
        run_until_idle("big", 5000, 1'b0);
        check_frames("big");
        chk("big_rd", rd_cycles, 4095);
        clear_obs();
        push_desc(16'd200, 8'd0);
        wait_bytes("mid", 100, 300);
        chk("mid_byte100", obs[99], exp_q[99]);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {q.ptr_fifo_rd, q.data_fifo_rd, q.tx_sof, q.tx_eof, q.tx_dv, q.tx_data, q.busy}, 0);
        chk("mid_rst_cnts", {q.frame_cnt, q.drop_cnt}, 0);
        ptr_q.delete();
        data_q.delete();
        exp_fcnt = 0;
        exp_dcnt = 0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_busy", q.busy, 0);
        chk("post_rst_dv", q.tx_dv, 0);
        clear_obs();
        push_desc(16'h5005, 8'd0);
        run_until_idle("recover", 100, 1'b0);
        check_frames("recover");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
